// File: rtl/axi_wr_addr_master.sv
// AXI write-address channel master: command FIFO feeding an in-order AW output register with auto IDs.
// Define AW_TIMEOUT_EN to enable the sticky AW stall watchdog (timeout_err); otherwise it is tied low.
module axi_wr_addr_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [31:0]                   cmd_addr,
  input  logic [3:0]                    cmd_len,
  output logic [3:0]                    awid,
  output logic [31:0]                   awaddr,
  output logic [3:0]                    awlen,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   issued_cnt,
  output logic                          busy,
  output logic                          timeout_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi_wr_addr_master: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE = 1'b0, ADDR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [35:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [3:0]      id_cnt_q, id_cnt_d;
  logic [3:0]      awid_q, awid_d;
  logic [31:0]     awaddr_q, awaddr_d;
  logic [3:0]      awlen_q, awlen_d;
  logic [15:0]     issued_q, issued_d;
  logic            push, load, hs, fifo_nempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fifo_nempty) state_d = ADDR;
      ADDR:    if (awready && !fifo_nempty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    awvalid = (state_q == ADDR);
    busy    = fifo_nempty || (state_q == ADDR);
  end

  // No push-through: readiness comes from the registered level only.
  assign fifo_nempty = (level_q != '0);
  assign cmd_ready   = (level_q != LW'(FIFO_DEPTH));
  assign push        = cmd_valid && cmd_ready;
  assign hs          = awvalid && awready;
  assign load        = (!awvalid || awready) && fifo_nempty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    id_cnt_d = id_cnt_q;
    awid_d   = awid_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    issued_d = issued_q;
    level_d  = level_q + LW'(push) - LW'(load);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) begin
      rd_ptr_d            = rd_ptr_q + 1'b1;
      {awaddr_d, awlen_d} = mem_q[rd_ptr_q];
      awid_d              = id_cnt_q;
      id_cnt_d            = id_cnt_q + 4'd1;
    end
    if (hs) issued_d = issued_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_len};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      id_cnt_q <= '0;
      awid_q   <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      issued_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      id_cnt_q <= id_cnt_d;
      awid_q   <= awid_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
      issued_q <= issued_d;
    end
  end

  assign awid       = awid_q;
  assign awaddr     = awaddr_q;
  assign awlen      = awlen_q;
  assign fifo_level = level_q;
  assign issued_cnt = issued_q;

`ifdef AW_TIMEOUT_EN
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;

  // The flag only reports; the pending AW beat is never retracted.
  always_comb begin
    stall_d = stall_q;
    err_d   = err_q;
    if (!awvalid || awready) begin
      stall_d = '0;
    end else begin
      if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
      if (int'(stall_q) + 1 >= TIMEOUT_CYCLES) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_wr_addr_master.sv
// Randomized scoreboard bench for axi_wr_addr_master: driver queues expected AW beats, negedge monitor checks them.
// Models the AW_TIMEOUT_EN watchdog too when that macro is defined for both bench and design.
module tb_axi_wr_addr_master;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [2:0]  fifo_level;
  logic [15:0] issued_cnt;
  logic        busy;
  logic        timeout_err;

  axi_wr_addr_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awvalid(awvalid), .awready(awready), .fifo_level(fifo_level),
    .issued_cnt(issued_cnt), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } exp_t;

  exp_t        q[$];
  int          cyc_now = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [3:0]  exp_id = '0;
  logic [15:0] exp_issued = '0;

  always @(posedge clk) cyc_now++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A command is accepted at the edge following the drive, so its entry is stamped with that edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [3:0] l, input logic r);
    @(posedge clk);
    #2;
    cmd_valid = v;
    cmd_addr  = a;
    cmd_len   = l;
    awready   = r;
    if (v && cmd_ready) begin
      q.push_back('{cyc_now + 1, exp_id, a, l});
      exp_id++;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
    check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_issued_cnt"}, 32'(issued_cnt), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_awid"}, 32'(awid), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk);
    #3;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    awready   = 1'b0;
    #1;
    reset_checks(tag);
    q.delete();
    exp_id = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      step(1'b0, 32'd0, 4'd0, 1'b1);
      n++;
    end
    check({tag, "_drain_left"}, 32'(q.size()), 32'd0);
  endtask

`ifdef AW_TIMEOUT_EN
  int stall = 0;
  bit to_pend = 1'b0;
  bit exp_err = 1'b0;
`endif

  always @(negedge clk) begin : monitor
    int nvis;
    bit ev;
    if (rst) begin
      exp_issued = '0;
`ifdef AW_TIMEOUT_EN
      stall   = 0;
      to_pend = 1'b0;
      exp_err = 1'b0;
`endif
    end else begin
      nvis = 0;
      foreach (q[i]) if (q[i].cyc <= cyc_now) nvis++;
      ev = (q.size() > 0) && (q[0].cyc < cyc_now);
      check("awvalid", 32'(awvalid), 32'(ev));
      if (ev) begin
        check("awid", 32'(awid), 32'(q[0].id));
        check("awaddr", awaddr, q[0].addr);
        check("awlen", 32'(awlen), 32'(q[0].len));
      end
      check("fifo_level", 32'(fifo_level), 32'(nvis - int'(ev)));
      check("cmd_ready", 32'(cmd_ready), 32'((nvis - int'(ev)) != DEPTH));
      check("busy", 32'(busy), 32'(nvis != 0));
      check("issued_cnt", 32'(issued_cnt), 32'(exp_issued));
`ifdef AW_TIMEOUT_EN
      if (to_pend) exp_err = 1'b1;
      check("timeout_err", 32'(timeout_err), 32'(exp_err));
      if (ev && !awready) begin
        stall++;
        if (stall >= TO_CYC) to_pend = 1'b1;
      end else begin
        stall = 0;
      end
`else
      check("timeout_err", 32'(timeout_err), 32'd0);
`endif
      if (ev && awready) begin
        void'(q.pop_front());
        exp_issued++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    rst = 1'b1;
    #1;
    reset_checks("por");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // single command
    step(1'b1, 32'h0000_1000, 4'd3, 1'b1);
    step(1'b0, 32'd0, 4'd0, 1'b1);
    drain("single", 20);
    check("single_issued", 32'(issued_cnt), 32'd1);

    // backpressure: held for ten cycles, then accepted
    step(1'b1, 32'h0000_2040, 4'd7, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 32'd0, 4'd0, 1'b0);
    drain("bp", 20);

    // fill: output register plus four FIFO entries, then a rejected sixth
    for (int i = 0; i < 6; i++) step(1'b1, 32'h0000_3000 + 32'(i * 64), 4'(i), 1'b0);
    #1;
    check("full_cmd_ready", 32'(cmd_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    drain("full", 20);

    // ID wrap after a fresh reset
    apply_reset("rst_a");
    for (int i = 0; i < 17; i++) step(1'b1, 32'h0001_0000 + 32'(i * 16), 4'(i % 16), 1'b1);
    drain("wrap", 40);
    check("wrap_issued", 32'(issued_cnt), 32'd17);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
    drain("rand", 40);

    // reset while an AW beat is stalled, then first ID restarts at 0
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_A000 + 32'(i), 4'd1, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b0);
    apply_reset("rst_mid");
    step(1'b1, 32'h0000_5550, 4'd2, 1'b1);
    drain("post_rst", 20);
    check("post_rst_issued", 32'(issued_cnt), 32'd1);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
